// File: rtl/sy_ppl_fpr_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : sy_ppl_fpr_file_mp
// Purpose  : Multi-ported physical floating-point register file with a
//            per-entry ready (value produced) bit. Writeback ports store data
//            and set ready. Rename allocation ports clear ready. A pipeline
//            flush marks every entry ready.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   SY_FPR_BYPASS_EN - when defined, same-cycle writeback data is forwarded
//                      to matching read ports.
// ----------------------------------------------------------------------------
// Ports:
//   clk_i          in   clock, rising edge
//   rst_i          in   asynchronous active-high reset
//   rd_idx_i       in   READ_PORT x IDX_W read indices (port i at [i*IDX_W +: IDX_W])
//   rd_data_o      out  READ_PORT x DATA_W read data
//   rd_rdy_o       out  READ_PORT ready flags of the indexed entries
//   wb_en_i        in   WRITE_PORT writeback enables (highest port wins)
//   wb_idx_i       in   WRITE_PORT x IDX_W writeback indices
//   wb_data_i      in   WRITE_PORT x DATA_W writeback data
//   alloc_en_i     in   ALLOC_PORT allocation enables
//   alloc_idx_i    in   ALLOC_PORT x IDX_W allocation indices
//   flush_i        in   mark all entries ready
//   wb_conflict_o  out  registered pulse: same-index writeback collision
// ============================================================================
module sy_ppl_fpr_file_mp #(
  parameter int READ_PORT  = 4,
  parameter int WRITE_PORT = 2,
  parameter int ALLOC_PORT = 2,
  parameter int DEPTH      = 64,  // PHY_FP_REG
  parameter int DATA_W     = 64,  // DWTH
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [READ_PORT*IDX_W-1:0]   rd_idx_i,
  output logic [READ_PORT*DATA_W-1:0]  rd_data_o,
  output logic [READ_PORT-1:0]         rd_rdy_o,
  input  logic [WRITE_PORT-1:0]        wb_en_i,
  input  logic [WRITE_PORT*IDX_W-1:0]  wb_idx_i,
  input  logic [WRITE_PORT*DATA_W-1:0] wb_data_i,
  input  logic [ALLOC_PORT-1:0]        alloc_en_i,
  input  logic [ALLOC_PORT*IDX_W-1:0]  alloc_idx_i,
  input  logic                         flush_i,
  output logic                         wb_conflict_o
);

  // Every index value the IDX_W-bit field can carry, and a constant mask that
  // marks which of them name a real entry. Looking the mask up avoids
  // comparisons that are constant when DEPTH is a power of two.
  localparam int                    IDX_SPAN = 1 << IDX_W;
  localparam logic [IDX_SPAN-1:0]   IN_RANGE = {IDX_SPAN{1'b1}} >> (IDX_SPAN - DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  rdy_q;
  logic [DEPTH-1:0]  rdy_d;
  logic              wb_conflict_q;
  logic              wb_conflict_d;

  // --------------------------------------------------------------------------
  // Port unpacking
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]  wb_idx    [WRITE_PORT];
  logic [DATA_W-1:0] wb_data   [WRITE_PORT];
  logic [WRITE_PORT-1:0] wb_ok;
  logic [IDX_W-1:0]  alloc_idx [ALLOC_PORT];
  logic [ALLOC_PORT-1:0] alloc_ok;

  generate
    for (genvar g = 0; g < WRITE_PORT; g++) begin : g_wb
      assign wb_idx[g]  = wb_idx_i[g*IDX_W +: IDX_W];
      assign wb_data[g] = wb_data_i[g*DATA_W +: DATA_W];
      // Out-of-range targets are dropped entirely.
      assign wb_ok[g]   = wb_en_i[g] & IN_RANGE[wb_idx[g]];
    end

    for (genvar g = 0; g < ALLOC_PORT; g++) begin : g_alloc
      assign alloc_idx[g] = alloc_idx_i[g*IDX_W +: IDX_W];
      assign alloc_ok[g]  = alloc_en_i[g] & IN_RANGE[alloc_idx[g]];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state computation
  // --------------------------------------------------------------------------
  // Precedence, lowest to highest: writeback (ascending port order, so the
  // highest-numbered port's data survives), then allocation (clears ready
  // even on a same-cycle writeback), then flush (sets every ready bit).
  always_comb begin
    mem_d = mem_q;
    rdy_d = rdy_q;
    for (int w = 0; w < WRITE_PORT; w++) begin
      if (wb_ok[w]) begin
        mem_d[wb_idx[w]] = wb_data[w];
        rdy_d[wb_idx[w]] = 1'b1;
      end
    end
    for (int a = 0; a < ALLOC_PORT; a++) begin
      if (alloc_ok[a]) begin
        rdy_d[alloc_idx[a]] = 1'b0;
      end
    end
    if (flush_i) begin
      rdy_d = '1;
    end
  end

  // A collision is two or more accepted writebacks naming the same entry.
  always_comb begin
    wb_conflict_d = 1'b0;
    for (int i = 0; i < WRITE_PORT; i++) begin
      for (int j = i + 1; j < WRITE_PORT; j++) begin
        if (wb_ok[i] && wb_ok[j] && (wb_idx[i] == wb_idx[j])) begin
          wb_conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdy_q         <= '1;
      wb_conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rdy_q         <= rdy_d;
      wb_conflict_q <= wb_conflict_d;
    end
  end

  assign wb_conflict_o = wb_conflict_q;

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < READ_PORT; g++) begin : g_rd
      logic [IDX_W-1:0]  rd_idx;
      logic              rd_ok;
      logic [DATA_W-1:0] rd_data;
      logic              rd_rdy;
`ifdef SY_FPR_BYPASS_EN
      logic              byp_hit;
`endif

      assign rd_idx = rd_idx_i[g*IDX_W +: IDX_W];
      assign rd_ok  = IN_RANGE[rd_idx];

      always_comb begin
        // Nonexistent entries read as a produced zero.
        rd_data = rd_ok ? mem_q[rd_idx] : '0;
        rd_rdy  = rd_ok ? rdy_q[rd_idx] : 1'b1;
`ifdef SY_FPR_BYPASS_EN
        byp_hit = 1'b0;
        // Ascending scan lets the highest-priority matching port win.
        for (int w = 0; w < WRITE_PORT; w++) begin
          if (wb_ok[w] && (wb_idx[w] == rd_idx)) begin
            rd_data = wb_data[w];
            rd_rdy  = 1'b1;
            byp_hit = 1'b1;
          end
        end
        // A same-cycle re-allocation means the forwarded value is stale
        // with respect to the new producer.
        if (byp_hit) begin
          for (int a = 0; a < ALLOC_PORT; a++) begin
            if (alloc_ok[a] && (alloc_idx[a] == rd_idx)) begin
              rd_rdy = 1'b0;
            end
          end
        end
`endif
      end

      assign rd_data_o[g*DATA_W +: DATA_W] = rd_data;
      assign rd_rdy_o[g]                   = rd_rdy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sy_ppl_fpr_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_sy_ppl_fpr_file_mp
// Purpose  : Self-checking bench for sy_ppl_fpr_file_mp (DEPTH=48, DATA_W=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sy_ppl_fpr_file_mp;

  localparam int RP = 4;
  localparam int WP = 2;
  localparam int AP = 2;
  localparam int DEPTH = 48;
  localparam int DW = 64;
  localparam int IW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          wb_en   [WP];
  logic [IW-1:0] wb_idx  [WP];
  logic [DW-1:0] wb_data [WP];
  logic          al_en   [AP];
  logic [IW-1:0] al_idx  [AP];
  logic          flush;
  logic [IW-1:0] rd_idx  [RP];

  logic [WP-1:0]    wb_en_f;
  logic [WP*IW-1:0] wb_idx_f;
  logic [WP*DW-1:0] wb_data_f;
  logic [AP-1:0]    al_en_f;
  logic [AP*IW-1:0] al_idx_f;
  logic [RP*IW-1:0] rd_idx_f;
  logic [RP*DW-1:0] rd_data_f;
  logic [RP-1:0]    rd_rdy_f;
  logic             conf;

  assign wb_en_f   = {wb_en[1], wb_en[0]};
  assign wb_idx_f  = {wb_idx[1], wb_idx[0]};
  assign wb_data_f = {wb_data[1], wb_data[0]};
  assign al_en_f   = {al_en[1], al_en[0]};
  assign al_idx_f  = {al_idx[1], al_idx[0]};
  assign rd_idx_f  = {rd_idx[3], rd_idx[2], rd_idx[1], rd_idx[0]};

  sy_ppl_fpr_file_mp #(
    .READ_PORT (RP),
    .WRITE_PORT(WP),
    .ALLOC_PORT(AP),
    .DEPTH     (DEPTH),
    .DATA_W    (DW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_idx_i     (rd_idx_f),
    .rd_data_o    (rd_data_f),
    .rd_rdy_o     (rd_rdy_f),
    .wb_en_i      (wb_en_f),
    .wb_idx_i     (wb_idx_f),
    .wb_data_i    (wb_data_f),
    .alloc_en_i   (al_en_f),
    .alloc_idx_i  (al_idx_f),
    .flush_i      (flush),
    .wb_conflict_o(conf)
  );

  // --------------------------------------------------------------------------
  // Reference model: plain arrays updated by the rules of the register file.
  // --------------------------------------------------------------------------
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_rdy [DEPTH];
  logic          m_conf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_rdy[i] = 1'b1;
      end
      m_conf = 1'b0;
    end else begin
      m_conf = 1'b0;
      for (int i = 0; i < WP; i++)
        for (int j = i + 1; j < WP; j++)
          if (wb_en[i] && wb_en[j] && wb_idx[i] == wb_idx[j] && int'(wb_idx[i]) < DEPTH)
            m_conf = 1'b1;
      for (int w = 0; w < WP; w++)
        if (wb_en[w] && int'(wb_idx[w]) < DEPTH) begin
          m_mem[wb_idx[w]] = wb_data[w];
          m_rdy[wb_idx[w]] = 1'b1;
        end
      for (int a = 0; a < AP; a++)
        if (al_en[a] && int'(al_idx[a]) < DEPTH)
          m_rdy[al_idx[a]] = 1'b0;
      if (flush)
        for (int i = 0; i < DEPTH; i++) m_rdy[i] = 1'b1;
    end
  end

  function automatic void exp_read(input logic [IW-1:0] idx,
                                   output logic [DW-1:0] d, output logic r);
    d = '0;
    r = 1'b1;
    if (int'(idx) < DEPTH) begin
      d = m_mem[idx];
      r = m_rdy[idx];
    end
`ifdef SY_FPR_BYPASS_EN
    begin
      logic hit;
      hit = 1'b0;
      for (int w = 0; w < WP; w++)
        if (wb_en[w] && wb_idx[w] == idx && int'(idx) < DEPTH) begin
          d = wb_data[w];
          r = 1'b1;
          hit = 1'b1;
        end
      if (hit)
        for (int a = 0; a < AP; a++)
          if (al_en[a] && al_idx[a] == idx) r = 1'b0;
    end
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int w = 0; w < WP; w++) begin
      wb_en[w] = 1'b0; wb_idx[w] = '0; wb_data[w] = '0;
    end
    for (int a = 0; a < AP; a++) begin
      al_en[a] = 1'b0; al_idx[a] = '0;
    end
    flush = 1'b0;
  endtask

  task automatic set_rd_all(input logic [IW-1:0] idx);
    for (int r = 0; r < RP; r++) rd_idx[r] = idx;
  endtask

  // --------------------------------------------------------------------------
  // Directed vectors: inputs applied for one cycle, then the registered state
  // of chk index is read with all write/alloc inputs idle.
  // --------------------------------------------------------------------------
  typedef struct {
    logic          w0e; logic [IW-1:0] w0i; logic [DW-1:0] w0d;
    logic          w1e; logic [IW-1:0] w1i; logic [DW-1:0] w1d;
    logic          a0e; logic [IW-1:0] a0i;
    logic          a1e; logic [IW-1:0] a1i;
    logic          fl;
    logic [IW-1:0] ci;  logic [DW-1:0] ed; logic er; logic ec;
  } vec_t;

  localparam int NT = 13;
  vec_t tbl [NT];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ed;
    logic          er;

    tbl[0]  = '{1'b1, 6'd5, 64'h3FF0000000000000, 1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd5, 64'h3FF0000000000000, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 6'd7, 64'h11, 1'b1, 6'd7, 64'h22, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 64'h22, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 64'h22, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 6'd9, 64'h55, 1'b0, 6'd0, 64'h0, 1'b1, 6'd9, 1'b0, 6'd0, 1'b0, 6'd9, 64'h55, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 6'd0, 64'h0, 1'b1, 6'd9, 64'h66, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd9, 64'h66, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 64'h0, 1'b1, 6'd3, 1'b1, 6'd4, 1'b0, 6'd4, 64'h0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 64'h0, 1'b1, 6'd6, 1'b0, 6'd0, 1'b1, 6'd6, 64'h0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd3, 64'h0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd4, 64'h0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 6'd50, 64'hAA, 1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd50, 64'h0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 6'd0, 64'h0, 1'b1, 6'd47, 64'hDEAD, 1'b1, 6'd50, 1'b0, 6'd0, 1'b0, 6'd47, 64'hDEAD, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 6'd0, 64'h1, 1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 1'b1, 6'd47, 1'b0, 6'd47, 64'hDEAD, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 6'd7, 64'h99, 1'b1, 6'd7, 64'h77, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 64'h77, 1'b1, 1'b0};

    clear_inputs();
    set_rd_all('0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state on all read ports.
    for (int r = 0; r < RP; r++) rd_idx[r] = IW'(r * 13);
    #1;
    for (int r = 0; r < RP; r++) begin
      check($sformatf("reset rd%0d data", r), rd_data_f[r*DW +: DW], '0);
      check($sformatf("reset rd%0d rdy", r), DW'(rd_rdy_f[r]), 64'h1);
    end
    check("reset conflict", DW'(conf), 64'h0);

    // Directed table.
    for (int t = 0; t < NT; t++) begin
      @(negedge clk);
      wb_en[0] = tbl[t].w0e; wb_idx[0] = tbl[t].w0i; wb_data[0] = tbl[t].w0d;
      wb_en[1] = tbl[t].w1e; wb_idx[1] = tbl[t].w1i; wb_data[1] = tbl[t].w1d;
      al_en[0] = tbl[t].a0e; al_idx[0] = tbl[t].a0i;
      al_en[1] = tbl[t].a1e; al_idx[1] = tbl[t].a1i;
      flush    = tbl[t].fl;
      @(posedge clk);
      #1;
      clear_inputs();
      set_rd_all(tbl[t].ci);
      #1;
      for (int r = 0; r < RP; r++) begin
        check($sformatf("vec%0d rd%0d data", t, r), rd_data_f[r*DW +: DW], tbl[t].ed);
        check($sformatf("vec%0d rd%0d rdy", t, r), DW'(rd_rdy_f[r]), DW'(tbl[t].er));
      end
      check($sformatf("vec%0d conflict", t), DW'(conf), DW'(tbl[t].ec));
    end

    // Same-cycle visibility of a write (forwarded only with bypass).
    @(negedge clk);
    wb_en[0] = 1'b1; wb_idx[0] = 6'd20; wb_data[0] = 64'h4000000000000000;
    set_rd_all(6'd20);
    #1;
`ifdef SY_FPR_BYPASS_EN
    check("samecyc data", rd_data_f[DW-1:0], 64'h4000000000000000);
`else
    check("samecyc data", rd_data_f[DW-1:0], 64'h0);
`endif
    check("samecyc rdy", DW'(rd_rdy_f[0]), 64'h1);
    @(posedge clk);
    #1;
    clear_inputs();
    #1;
    check("nextcyc data", rd_data_f[DW-1:0], 64'h4000000000000000);

    // Asynchronous reset between edges, held across a write edge.
    @(negedge clk);
    wb_en[0] = 1'b1; wb_idx[0] = 6'd11; wb_data[0] = 64'h1234;
    rd_idx[0] = 6'd5; rd_idx[1] = 6'd47; rd_idx[2] = 6'd7; rd_idx[3] = 6'd20;
    #2;
    rst = 1'b1;
    #1;
    for (int r = 0; r < RP; r++) begin
      check($sformatf("asyncrst rd%0d data", r), rd_data_f[r*DW +: DW], 64'h0);
      check($sformatf("asyncrst rd%0d rdy", r), DW'(rd_rdy_f[r]), 64'h1);
    end
    @(posedge clk);
    #1;
    clear_inputs();
    rd_idx[0] = 6'd11;
    #1;
    check("midwrite data", rd_data_f[DW-1:0], 64'h0);
    @(negedge clk);
    rst = 1'b0;
    wb_en[0] = 1'b1; wb_idx[0] = 6'd12; wb_data[0] = 64'hCAFE;
    @(posedge clk);
    #1;
    clear_inputs();
    rd_idx[0] = 6'd12;
    #1;
    check("firstwrite data", rd_data_f[DW-1:0], 64'hCAFE);
    check("firstwrite rdy", DW'(rd_rdy_f[0]), 64'h1);

    // Randomized traffic against the model, indices biased to collide.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int w = 0; w < WP; w++) begin
        wb_en[w]   = 1'($urandom_range(0, 1));
        wb_idx[w]  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
        wb_data[w] = {$urandom, $urandom};
      end
      for (int a = 0; a < AP; a++) begin
        al_en[a]  = ($urandom_range(0, 2) == 0);
        al_idx[a] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
      end
      flush = ($urandom_range(0, 15) == 0);
      for (int r = 0; r < RP; r++)
        rd_idx[r] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
      #1;
      for (int r = 0; r < RP; r++) begin
        exp_read(rd_idx[r], ed, er);
        check($sformatf("rnd%0d rd%0d data", c, r), rd_data_f[r*DW +: DW], ed);
        check($sformatf("rnd%0d rd%0d rdy", c, r), DW'(rd_rdy_f[r]), DW'(er));
      end
      check($sformatf("rnd%0d conflict", c), DW'(conf), DW'(m_conf));
    end

    @(negedge clk);
    clear_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sy_ppl_fpr_file_mp.md
SY_PPL_FPR_FILE_MP -- requirements
Module: sy_ppl_fpr_file_mp

Interface
REQ-001 SHALL have parameter READ_PORT, default 4, number of read ports.
REQ-002 SHALL have parameter WRITE_PORT, default 2, number of writeback ports; port WRITE_PORT-1 has highest priority.
REQ-003 SHALL have parameter ALLOC_PORT, default 2, number of rename-allocation ports.
REQ-004 SHALL have parameter DEPTH, default PHY_FP_REG, number of physical FP registers; IDX_W = $clog2(DEPTH).
REQ-005 SHALL have parameter DATA_W, default DWTH, register width.
REQ-006 clk_i  input  1  single clock, rising edge.
REQ-007 rst_i  input  1  asynchronous, active-high reset.
REQ-008 rd_idx_i  input  READ_PORT x IDX_W  read indices.
REQ-009 rd_data_o  output  READ_PORT x DATA_W  read data.
REQ-010 rd_rdy_o  output  READ_PORT  ready (value produced) flag of the indexed register.
REQ-011 wb_en_i / wb_idx_i / wb_data_i  input  WRITE_PORT x (1 / IDX_W / DATA_W)  writeback ports (LSU, FPU, ...).
REQ-012 alloc_en_i / alloc_idx_i  input  ALLOC_PORT x (1 / IDX_W)  destination allocation from rename; marks register not-ready.
REQ-013 flush_i  input  1  pipeline flush; marks all registers ready.
REQ-014 wb_conflict_o  output  1  registered pulse: two or more enabled writeback ports targeted one index in the previous cycle.

Function
REQ-015 Storage SHALL be DEPTH x DATA_W flops plus a DEPTH-bit ready vector.
REQ-016 Writes SHALL take effect at the rising edge after wb_en_i sampled high.
REQ-017 Same-index writes in one cycle: highest-numbered port's data SHALL be stored; others discarded.
REQ-018 Writeback SHALL set the target's ready bit at the same edge.
REQ-019 Allocation SHALL clear the target's ready bit at the next edge; data unchanged.
REQ-020 Allocation and writeback to one index in one cycle: allocation SHALL win (ready=0); data is still written.
REQ-021 flush_i high SHALL set all ready bits to 1 at the next edge, overriding same-cycle allocations; same-cycle writebacks still write data.
REQ-022 Reads SHALL be combinational: rd_data_o[i] = array[rd_idx_i[i]], rd_rdy_o[i] = ready[rd_idx_i[i]].
REQ-023 Index >= DEPTH (non-power-of-2 DEPTH): reads SHALL return data 0, ready 1; writes and allocations SHALL be ignored.
REQ-024 wb_conflict_o SHALL assert for exactly one cycle, the cycle after a REQ-017 collision; it is 0 otherwise.
REQ-025 Read ports SHALL be independent; any number may address the same index.

Reset
REQ-026 rst_i high SHALL asynchronously clear all data entries to 0, set all ready bits to 1, and clear wb_conflict_o.
REQ-027 After rst_i deassertion, the first write SHALL be accepted on the first rising edge.
REQ-028 Reset mid-write SHALL leave the entry at 0; no partial update.

Configuration
REQ-029 Macro SY_FPR_BYPASS_EN SHALL select write-to-read forwarding.
REQ-030 With SY_FPR_BYPASS_EN defined: if an enabled wb port matches rd_idx_i[i] in the same cycle, rd_data_o[i] SHALL be that port's data (highest-priority match) and rd_rdy_o[i] SHALL be 1, unless a same-cycle allocation to that index is present (then rd_rdy_o[i]=0).
REQ-031 Without SY_FPR_BYPASS_EN: reads SHALL reflect only registered state; a write becomes visible one cycle later.

Verification
REQ-032 Reset: assert rst_i between edges -> all rd_data_o=0, rd_rdy_o=1 immediately, before any clock edge.
REQ-033 Write/read: wb0 idx 5 data 0x3FF0000000000000 -> next cycle rd_idx=5 gives that data, ready 1; same cycle gives 0 without bypass, data with SY_FPR_BYPASS_EN.
REQ-034 Collision: wb0 and wb1 both idx 7, data 0x11 / 0x22 -> entry 7 = 0x22, wb_conflict_o=1 one cycle only.
REQ-035 Alloc/wb race: alloc idx 9 and wb idx 9 data 0x55 in same cycle -> entry 9 = 0x55, rd_rdy_o=0; later wb idx 9 -> ready 1.
REQ-036 Flush: alloc idx 3, 4 then flush_i with alloc idx 6 -> next cycle ready for 3, 4, 6 all 1.
REQ-037 Out-of-range (DEPTH=48): wb idx 50 data 0xAA -> no entry changes; rd_idx=50 returns 0, ready 1.
